mem_arbiter: RTL



---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// CPU-side ports and memory-bus signals of the instruction/data bus arbiter.
// The master view belongs to the arbiter, the slave view to the CPU/bus side.
interface mem_arbiter_if;
    logic [31:0] i_addr_i;
    logic        o_valid_i;
    logic [31:0] o_data_i;
    logic [31:0] i_addr_d;
    logic        i_rd_d;
    logic [3:0]  i_we_d;
    logic [31:0] i_data_d;
    logic        o_valid_d;
    logic [31:0] o_data_d;
    logic [31:0] o_mem_addr;
    logic        o_mem_req;
    logic        o_mem_rd;
    logic [3:0]  o_mem_we;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_ack;
    logic        o_bus_err;

    modport master (
        input  i_addr_i, i_addr_d, i_rd_d, i_we_d, i_data_d,
        input  i_mem_rdata, i_mem_ack,
        output o_valid_i, o_data_i, o_valid_d, o_data_d,
        output o_mem_addr, o_mem_req, o_mem_rd, o_mem_we,
        output o_mem_wdata, o_bus_err
    );

    modport slave (
        output i_addr_i, i_addr_d, i_rd_d, i_we_d, i_data_d,
        output i_mem_rdata, i_mem_ack,
        input  o_valid_i, o_data_i, o_valid_d, o_data_d,
        input  o_mem_addr, o_mem_req, o_mem_rd, o_mem_we,
        input  o_mem_wdata, o_bus_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port memory bus between instruction fetch and data access.
// One-entry address-tagged instruction buffer; IDLE/IFETCH/DACC sequencer.
module mem_arbiter #(
    parameter bit          DATA_PRIO = 1'b1,
    parameter int unsigned TIMEOUT   = 0,
    parameter int unsigned TO_W      = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, IFETCH, DACC} state_t;

    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

    state_t          state;
    logic            ibuf_valid;
    logic [31:0]     ibuf_tag;
    logic            d_done;
    logic [TO_W-1:0] cnt;

    logic        ihit;
    logic        dreq;
    logic        advance;
    logic        ipend;
    logic        dpend;
    logic        pick_d;
    logic        ack;
    logic        tmo;
    logic        fin;
    logic [31:0] rdata;

    assign ihit    = ibuf_valid && (ibuf_tag == bus.i_addr_i);
    assign dreq    = bus.i_rd_d || (|bus.i_we_d);
    assign advance = bus.o_valid_i && bus.o_valid_d;
    assign ipend   = !ihit;
    assign dpend   = dreq && !d_done;
    assign pick_d  = dpend && (DATA_PRIO || !ipend);

    assign bus.o_valid_i = ihit;
    assign bus.o_valid_d = !dreq || d_done;

    // An ack in the last allowed cycle still wins over the timeout.
    assign ack   = bus.o_mem_req && bus.i_mem_ack;
    assign tmo   = (TIMEOUT != 0) && bus.o_mem_req && !bus.i_mem_ack
                   && (cnt == TO_LAST);
    assign fin   = ack || tmo;
    assign rdata = ack ? bus.i_mem_rdata : 32'h0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            bus.o_mem_req   <= 1'b0;
            bus.o_mem_rd    <= 1'b0;
            bus.o_mem_we    <= 4'b0;
            bus.o_mem_addr  <= 32'h0;
            bus.o_mem_wdata <= 32'h0;
            ibuf_valid      <= 1'b0;
            ibuf_tag        <= 32'h0;
            bus.o_data_i    <= 32'h0;
            d_done          <= 1'b0;
            bus.o_data_d    <= 32'h0;
            bus.o_bus_err   <= 1'b0;
            cnt             <= '0;
        end else begin
            if (advance)
                d_done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (pick_d) begin
                        state           <= DACC;
                        bus.o_mem_req   <= 1'b1;
                        bus.o_mem_addr  <= {bus.i_addr_d[31:2], 2'b00};
                        bus.o_mem_rd    <= bus.i_rd_d;
                        bus.o_mem_we    <= bus.i_we_d;
                        bus.o_mem_wdata <= bus.i_data_d;
                    end else if (ipend) begin
                        state          <= IFETCH;
                        bus.o_mem_req  <= 1'b1;
                        bus.o_mem_addr <= {bus.i_addr_i[31:2], 2'b00};
                        bus.o_mem_rd   <= 1'b1;
                        bus.o_mem_we   <= 4'b0;
                    end
                end
                IFETCH: begin
                    if (fin) begin
                        state         <= IDLE;
                        bus.o_mem_req <= 1'b0;
                        bus.o_mem_rd  <= 1'b0;
                        bus.o_data_i  <= rdata;
                        ibuf_tag      <= bus.o_mem_addr;
                        ibuf_valid    <= 1'b1;
                        if (tmo)
                            bus.o_bus_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DACC: begin
                    if (fin) begin
                        state         <= IDLE;
                        bus.o_mem_req <= 1'b0;
                        bus.o_mem_rd  <= 1'b0;
                        bus.o_mem_we  <= 4'b0;
                        d_done        <= 1'b1;
                        if (bus.o_mem_rd || tmo)
                            bus.o_data_d <= rdata;
                        // A store over the buffered word makes it stale.
                        if ((|bus.o_mem_we)
                            && bus.o_mem_addr[31:2] == ibuf_tag[31:2])
                            ibuf_valid <= 1'b0;
                        if (tmo)
                            bus.o_bus_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
